cpu_bus_tracer: RTL and testbench

//  Sits directly downstream of the 6502 core, snooping its bus (AB, DO, DI, WE) on the cpu clock domain.

---
 rtl/cpu_trace_pkg.sv | 31 +++
 rtl/trace_fifo_ram.sv | 82 ++++++++
 rtl/cpu_bus_tracer.sv | 174 +++++++++++++++++
 tb/tb_cpu_bus_tracer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the 6502 bus tracer.
//   state_e    : capture FSM states
//   ENT_*      : bit offsets of the fields in a trace entry {we, data[7:0], addr[15:0]}
//   make_entry : packs one entry from its fields
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned ENT_ADDR = 0;
  localparam int unsigned ENT_DATA = 16;
  localparam int unsigned ENT_WE   = 24;
  localparam int unsigned ENT_W    = 25;

  typedef logic [ENT_W-1:0] entry_t;

  function automatic entry_t make_entry(input logic we, input logic [7:0] data,
                                        input logic [15:0] addr);
    entry_t e;
    e                  = '0;
    e[ENT_WE]          = we;
    e[ENT_DATA +: 8]   = data;
    e[ENT_ADDR +: 16]  = addr;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo_ram.sv
// Circular trace storage: DEPTH entries with write/read pointers and a fill level.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : empty the buffer (pointers and level to zero)
//   push_i       : write wdata_i; when full it is accepted only with a pop or with ovw_i
//   ovw_i        : a push into a full buffer without pop discards the oldest entry
//   pop_i        : drop the head entry (ignored when empty)
//   rdata_o      : head entry (first-word fall-through)
//   level_o      : entries held, 0..DEPTH
//   full_o       : level_o == DEPTH
module trace_fifo_ram
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   ovw_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]   LevelMax = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   LevelOne = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;
  logic            empty, do_pop, do_wr, drop_oldest;

  always_comb begin
    full_o      = (level_q == LevelMax);
    empty       = (level_q == '0);
    do_pop      = pop_i && !empty;
    do_wr       = push_i && (!full_o || do_pop || ovw_i);
    // Overwrite: the slot being written is the current head, so the head moves on.
    drop_oldest = do_wr && full_o && !do_pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop || drop_oldest) rd_ptr_d = rd_ptr_q + PtrOne;
    if (do_wr && !do_pop && !full_o) begin
      level_d = level_q + LevelOne;
    end else if (do_pop && !do_wr) begin
      level_d = level_q - LevelOne;
    end
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/cpu_bus_tracer.sv
// Snoops the 6502 bus and records completed bus cycles into a circular trace buffer.
// Capture runs from arm until POST_CNT entries after the first trigger-address entry.
//   clk, reset         : cpu clock, synchronous active-high reset
//   cpu_addr/do/di/we  : core bus (di valid the cycle after its address)
//   arm                : pulse; clear buffer and flags, start capture
//   trig_addr          : trigger address
//   stall_en           : hold the core via cpu_rdy instead of dropping when full after trigger
//   cpu_rdy            : to core RDY
//   rd_en/rd_valid/rd_data : FWFT drain port, rd_data = {we, data, addr}
//   level              : entries held
//   triggered/overflow : sticky status since last arm
module cpu_bus_tracer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned POST_CNT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_do,
  input  logic [7:0]             cpu_di,
  input  logic                   cpu_we,
  input  logic                   arm,
  input  logic [15:0]            trig_addr,
  input  logic                   stall_en,
  output logic                   cpu_rdy,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [ENT_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   triggered,
  output logic                   overflow
);

  localparam int unsigned PostW = $clog2(DEPTH);
  localparam logic [PostW-1:0] PostInit = PostW'(POST_CNT);
  localparam logic [PostW-1:0] PostOne  = PostW'(1);

  state_e           state_q, state_d;
  logic [PostW-1:0] post_q, post_d;
  logic             triggered_q, triggered_d;
  logic             overflow_q, overflow_d;

  // Launch stage: bus cycle whose read data arrives next cycle.
  logic             l_valid_q;
  logic [15:0]      l_addr_q;
  logic [7:0]       l_do_q;
  logic             l_we_q;

  // Completed entry waiting for space while the core is stalled.
  logic             hold_valid_q, hold_valid_d;
  entry_t           hold_ent_q, hold_ent_d;

  entry_t           cmp_ent, fifo_rdata;
  logic             cmp_valid, cmp_hit;
  logic             full, pop, stall;
  logic             fifo_push, fifo_pop, fifo_clr, fifo_ovw;

  always_comb begin
    rd_valid = (level != '0) && (state_q != StArmed);
    pop      = rd_en && rd_valid;
    stall    = (state_q == StPost) && full && stall_en && !pop;
    cpu_rdy  = !stall;
    rd_data  = rd_valid ? fifo_rdata : '0;

    cmp_valid = hold_valid_q || l_valid_q;
    cmp_ent   = hold_valid_q ? hold_ent_q
                             : make_entry(l_we_q, l_we_q ? l_do_q : cpu_di, l_addr_q);
    cmp_hit   = (cmp_ent[ENT_ADDR +: 16] == trig_addr);
  end

  always_comb begin
    state_d      = state_q;
    post_d       = post_q;
    triggered_d  = triggered_q;
    overflow_d   = overflow_q;
    hold_valid_d = 1'b0;
    hold_ent_d   = hold_ent_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_clr     = 1'b0;
    fifo_ovw     = (state_q == StArmed);

    if (arm) begin
      // Any completion in flight belongs to the previous capture and is discarded.
      fifo_clr    = 1'b1;
      state_d     = StArmed;
      post_d      = '0;
      triggered_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: fifo_pop = pop;
        StArmed: begin
          if (cmp_valid) begin
            fifo_push = 1'b1;
            if (cmp_hit) begin
              triggered_d = 1'b1;
              post_d      = PostInit;
              state_d     = StPost;
            end
          end
        end
        StPost: begin
          fifo_pop = pop;
          if (cmp_valid) begin
            if (!full || pop) begin
              fifo_push = 1'b1;
              post_d    = post_q - PostOne;
              if (post_q == PostOne) state_d = StDone;
            end else if (stall_en) begin
              hold_valid_d = 1'b1;
              hold_ent_d   = cmp_ent;
            end else begin
              overflow_d = 1'b1;
              post_d     = post_q - PostOne;
              if (post_q == PostOne) state_d = StDone;
            end
          end
        end
        StDone: fifo_pop = pop;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      post_q       <= '0;
      triggered_q  <= 1'b0;
      overflow_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_ent_q   <= '0;
      l_valid_q    <= 1'b0;
      l_addr_q     <= '0;
      l_do_q       <= '0;
      l_we_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      post_q       <= post_d;
      triggered_q  <= triggered_d;
      overflow_q   <= overflow_d;
      hold_valid_q <= hold_valid_d;
      hold_ent_q   <= hold_ent_d;
      l_valid_q    <= cpu_rdy;
      if (cpu_rdy) begin
        l_addr_q <= cpu_addr;
        l_do_q   <= cpu_do;
        l_we_q   <= cpu_we;
      end
    end
  end

  trace_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .ovw_i   (fifo_ovw),
    .pop_i   (fifo_pop),
    .wdata_i (cmp_ent),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (full)
  );

  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cpu_bus_tracer.sv
module tb_cpu_bus_tracer;

  localparam int DEPTH    = 16;
  localparam int POST_CNT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_we;
  logic        arm;
  logic [15:0] trig_addr;
  logic        stall_en;
  logic        cpu_rdy;
  logic        rd_en;
  logic        rd_valid;
  logic [24:0] rd_data;
  logic [4:0]  level;
  logic        triggered;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_bus_tracer #(
    .DEPTH    (DEPTH),
    .POST_CNT (POST_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_do    (cpu_do),
    .cpu_di    (cpu_di),
    .cpu_we    (cpu_we),
    .arm       (arm),
    .trig_addr (trig_addr),
    .stall_en  (stall_en),
    .cpu_rdy   (cpu_rdy),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .level     (level),
    .triggered (triggered),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: trace contents as a queue, capture phase as a small integer.
  localparam int PhIdle = 0, PhArmed = 1, PhPost = 2, PhDone = 3;
  int          m_ph;
  logic [24:0] m_q[$];
  bit          m_trig, m_ovf;
  int          m_post;
  bit          m_pend;      // bus cycle launched, data due next cycle
  logic [15:0] m_paddr;
  logic [7:0]  m_pdo;
  logic        m_pwe;
  bit          m_held;      // completed entry waiting for room while core is held
  logic [24:0] m_hent;

  function automatic bit m_rvalid();
    return (m_q.size() != 0) && (m_ph != PhArmed);
  endfunction

  function automatic bit m_rdy();
    return !(m_ph == PhPost && m_q.size() == DEPTH && stall_en && !(rd_en && m_rvalid()));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ph   = PhIdle;
    m_trig = 0;
    m_ovf  = 0;
    m_post = 0;
    m_pend = 0;
    m_held = 0;
  endtask

  task automatic compare_model();
    logic [24:0] head;
    head = '0;
    if (m_rvalid()) head = m_q[0];
    check_eq("level", 32'(level), 32'(m_q.size()));
    check_eq("rd_valid", 32'(rd_valid), 32'(m_rvalid()));
    check_eq("rd_data", 32'(rd_data), 32'(head));
    check_eq("cpu_rdy", 32'(cpu_rdy), 32'(m_rdy()));
    check_eq("triggered", 32'(triggered), 32'(m_trig));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic post_tick();
    m_post--;
    if (m_post == 0) m_ph = PhDone;
  endtask

  task automatic model_edge();
    bit          pop, rdy, have;
    logic [24:0] ent;
    pop = rd_en && m_rvalid();
    rdy = m_rdy();
    if (reset) begin
      model_reset();
      return;
    end
    have   = m_held || m_pend;
    ent    = m_held ? m_hent : {m_pwe, (m_pwe ? m_pdo : cpu_di), m_paddr};
    m_held = 0;
    if (arm) begin
      m_q.delete();
      m_ph   = PhArmed;
      m_trig = 0;
      m_ovf  = 0;
    end else begin
      case (m_ph)
        PhArmed: begin
          if (have) begin
            if (m_q.size() == DEPTH) void'(m_q.pop_front());
            m_q.push_back(ent);
            if (ent[15:0] == trig_addr) begin
              m_trig = 1;
              m_post = POST_CNT;
              m_ph   = PhPost;
            end
          end
        end
        PhPost: begin
          if (pop) void'(m_q.pop_front());
          if (have) begin
            if (m_q.size() < DEPTH) begin
              m_q.push_back(ent);
              post_tick();
            end else if (stall_en) begin
              m_held = 1;
              m_hent = ent;
            end else begin
              m_ovf = 1;
              post_tick();
            end
          end
        end
        default: if (pop) void'(m_q.pop_front());
      endcase
    end
    m_pend = rdy;
    if (rdy) begin
      m_paddr = cpu_addr;
      m_pdo   = cpu_do;
      m_pwe   = cpu_we;
    end
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model, take the edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input logic [7:0] di, input logic rd, input logic ar);
    cpu_addr = a;
    cpu_we   = w;
    cpu_do   = d;
    cpu_di   = di;
    rd_en    = rd;
    arm      = ar;
  endtask

  // Arm, PRE pre-trigger cycles, then the trigger address, then NPOST cycles without reads.
  task automatic capture(input int pre, input int npost, input logic [15:0] base);
    drive(base, 1'b0, 8'h00, 8'($urandom), 1'b0, 1'b1);
    step();
    for (int i = 1; i < pre; i++) begin
      drive(base + 16'(i), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      step();
    end
    drive(trig_addr, 1'b0, 8'h00, 8'($urandom), 1'b0, 1'b0);
    step();
    for (int i = 0; i < npost; i++) begin
      drive(16'h3000 + 16'(i), 1'b0, 8'h00, 8'($urandom), 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    reset     = 1'b1;
    trig_addr = 16'h0401;
    stall_en  = 1'b0;
    drive(16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_rdy", 32'(cpu_rdy), 32'd1);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);

    // Read trace
    drive(16'h0400, 1'b0, 8'h00, 8'h11, 1'b0, 1'b1);
    step();
    drive(16'h0401, 1'b0, 8'h00, 8'hA9, 1'b0, 1'b0);
    step();
    drive(16'h0500, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0);
    step();
    check_eq("rt_trig", 32'(triggered), 32'd1);
    check_eq("rt_entry0", 32'(rd_data), 32'h00A90400);
    drive(16'h0502, 1'b0, 8'h00, 8'h33, 1'b1, 1'b0);
    step();
    check_eq("rt_entry1", 32'(rd_data), 32'h00050401);

    // Write capture: data comes from cpu_do
    trig_addr = 16'h0200;
    drive(16'h0200, 1'b1, 8'h55, 8'hEE, 1'b0, 1'b1);
    step();
    drive(16'h0300, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b0);
    step();
    check_eq("wr_entry", 32'(rd_data), 32'h01550200);

    // Pre-trigger wrap, no stall: post entries find the buffer full and are dropped
    trig_addr = 16'h0401;
    stall_en  = 1'b0;
    capture(30, 10, 16'h1000);
    check_eq("wrap_level", 32'(level), 32'd16);
    check_eq("wrap_oldest", 32'(rd_data[15:0]), 32'h100F);
    check_eq("wrap_ovf", 32'(overflow), 32'd1);

    // Stall: 12 pre + trigger, buffer fills three entries into POST
    stall_en = 1'b1;
    capture(12, 8, 16'h2000);
    check_eq("stall_level", 32'(level), 32'd16);
    check_eq("stall_rdy0", 32'(cpu_rdy), 32'd0);
    rd_en = 1'b1;
    #1;
    check_eq("stall_rdy_pop", 32'(cpu_rdy), 32'd1);
    step();
    rd_en = 1'b0;
    #1;
    check_eq("stall_refill", 32'(level), 32'd16);
    check_eq("stall_rdy1", 32'(cpu_rdy), 32'd0);
    check_eq("stall_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive(16'h3100 + 16'(i), 1'b0, 8'h00, 8'($urandom), 1'b1, 1'b0);
      step();
    end

    // Drop: same fill without stall
    stall_en = 1'b0;
    capture(12, 12, 16'h2000);
    check_eq("drop_rdy", 32'(cpu_rdy), 32'd1);
    check_eq("drop_ovf", 32'(overflow), 32'd1);
    check_eq("drop_level", 32'(level), 32'd16);
    drive(16'h3200, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    rd_en = 1'b0;
    step();
    step();
    check_eq("drop_done", 32'(level), 32'd15);

    // Reset and arm mid-POST
    stall_en = 1'b1;
    capture(14, 4, 16'h2400);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rmid_level", 32'(level), 32'd0);
    check_eq("rmid_trig", 32'(triggered), 32'd0);
    check_eq("rmid_rdy", 32'(cpu_rdy), 32'd1);
    check_eq("rmid_valid", 32'(rd_valid), 32'd0);
    capture(14, 4, 16'h2400);
    drive(16'h2600, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    arm = 1'b0;
    check_eq("amid_level", 32'(level), 32'd0);
    check_eq("amid_trig", 32'(triggered), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) stall_en = 1'($urandom);
      drive(($urandom_range(0, 14) == 0) ? trig_addr : {8'h12, 8'($urandom_range(0, 15))},
            1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 120) == 0));
      reset = ($urandom_range(0, 600) == 0);
      step();
    end
    reset = 1'b0;
    arm   = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
